// File: rtl/branch_compare_stage.sv
// Branch compare/redirect: A-B subtract gives eq/lts/ltu, funct3 picks the condition, emits next PC and mispredict.
// Latency: 2 cycles from accept to out_valid; 1 entry/cycle when out_ready stays high.
// Backpressure: out_ready low holds S2, S1 fills, then in_ready drops; flush kills both stages.
module branch_compare_stage #(
    parameter int XLEN      = 64,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_a,
    input  logic [XLEN-1:0]      in_b,
    input  logic [2:0]           in_funct3,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_imm,
    input  logic                 in_pred_taken,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_taken,
    output logic [XLEN-1:0]      out_next_pc,
    output logic                 out_mispredict,
    output logic                 out_illegal,
    output logic [CNT_WIDTH-1:0] mispredict_cnt
);

    logic            s1_valid;
    logic [XLEN-1:0] s1_a, s1_b, s1_pc, s1_imm, s1_diff;
    logic [2:0]      s1_funct3;
    logic            s1_pred, s1_c;

    logic            s1_adv, accept;
    logic [XLEN:0]   sum;

    // Carry out of a + ~b + 1 is set exactly when a >= b unsigned.
    assign sum      = {1'b0, in_a} + {1'b0, ~in_b} + {{XLEN{1'b0}}, 1'b1};
    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !reset && !flush && (!s1_valid || s1_adv);
    assign accept   = in_valid && in_ready;

    logic            eq, lts, ltu;
    logic            ev_taken, ev_illegal, ev_mispredict;
    logic [XLEN-1:0] ev_next_pc;

    assign eq  = (s1_diff == '0);
    assign lts = (s1_a[XLEN-1] ^ s1_b[XLEN-1]) ? s1_a[XLEN-1] : s1_diff[XLEN-1];
    assign ltu = !s1_c;

    always_comb begin
        ev_taken   = 1'b0;
        ev_illegal = 1'b0;
        case (s1_funct3)
            3'b000:  ev_taken = eq;
            3'b001:  ev_taken = !eq;
            3'b100:  ev_taken = lts;
            3'b101:  ev_taken = !lts;
            3'b110:  ev_taken = ltu;
            3'b111:  ev_taken = !ltu;
            default: ev_illegal = 1'b1;
        endcase
        ev_next_pc    = ev_taken ? (s1_pc + s1_imm) : (s1_pc + XLEN'(4));
        ev_mispredict = !ev_illegal && (ev_taken != s1_pred);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid       <= 1'b0;
            s1_a           <= '0;
            s1_b           <= '0;
            s1_pc          <= '0;
            s1_imm         <= '0;
            s1_diff        <= '0;
            s1_funct3      <= '0;
            s1_pred        <= 1'b0;
            s1_c           <= 1'b0;
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_next_pc    <= '0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            // A handshake in the flush cycle still reaches the consumer, so it counts.
            if (out_valid && out_ready && out_mispredict && (mispredict_cnt != '1))
                mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);

            if (flush) begin
                s1_valid       <= 1'b0;
                out_valid      <= 1'b0;
                out_taken      <= 1'b0;
                out_next_pc    <= '0;
                out_mispredict <= 1'b0;
                out_illegal    <= 1'b0;
            end else begin
                if (accept) begin
                    s1_valid  <= 1'b1;
                    s1_a      <= in_a;
                    s1_b      <= in_b;
                    s1_pc     <= in_pc;
                    s1_imm    <= in_imm;
                    s1_funct3 <= in_funct3;
                    s1_pred   <= in_pred_taken;
                    s1_diff   <= sum[XLEN-1:0];
                    s1_c      <= sum[XLEN];
                end else if (s1_adv) begin
                    s1_valid <= 1'b0;
                end

                if (s1_adv) begin
                    out_valid      <= 1'b1;
                    out_taken      <= ev_taken;
                    out_next_pc    <= ev_next_pc;
                    out_mispredict <= ev_mispredict;
                    out_illegal    <= ev_illegal;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_compare_stage.sv
// Bench for branch_compare_stage: directed corner cases plus randomized traffic against a queue-based model.
module tb_branch_compare_stage;
    localparam int XLEN = 64;
    localparam int CW   = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [63:0]     in_a = '0, in_b = '0, in_pc = '0, in_imm = '0;
    logic [2:0]      in_funct3 = '0;
    logic            in_pred_taken = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_taken;
    logic [63:0]     out_next_pc;
    logic            out_mispredict;
    logic            out_illegal;
    logic [CW-1:0]   mispredict_cnt;

    branch_compare_stage #(.XLEN(XLEN), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_funct3(in_funct3), .in_pc(in_pc),
        .in_imm(in_imm), .in_pred_taken(in_pred_taken),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_next_pc(out_next_pc),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        taken;
        logic [63:0] npc;
        logic        mis;
        logic        ill;
    } res_t;

    res_t          exp_q[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [CW-1:0] cnt_model = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: branch semantics straight from the ISA rules using native comparisons.
    function automatic res_t ref_model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                                       input logic [63:0] pc, input logic [63:0] imm, input logic pred);
        res_t r;
        logic cond;
        cond = 1'b0;
        r.ill = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3)
            3'b000:  cond = (a == b);
            3'b001:  cond = (a != b);
            3'b100:  cond = ($signed(a) <  $signed(b));
            3'b101:  cond = ($signed(a) >= $signed(b));
            3'b110:  cond = (a <  b);
            3'b111:  cond = (a >= b);
            default: cond = 1'b0;
        endcase
        r.taken = cond;
        r.npc   = cond ? pc + imm : pc + 64'd4;
        r.mis   = !r.ill && (cond != pred);
        return r;
    endfunction

    function automatic logic [63:0] sx8(input int v);
        logic [7:0] b8;
        b8 = v[7:0];
        return {{56{b8[7]}}, b8};
    endfunction

    // Monitor: scoreboard, counter model and hold-stability check, sampled on the falling edge.
    res_t prev_out;
    logic prev_stall = 1'b0;
    logic prev_flush = 1'b0;
    always @(negedge clk) begin
        res_t got, e;
        got = {out_taken, out_next_pc, out_mispredict, out_illegal};
        if (reset) begin
            exp_q.delete();
            cnt_model  = '0;
            prev_stall = 1'b0;
            prev_flush = 1'b0;
        end else begin
            chk("mispredict_cnt", 64'(mispredict_cnt), 64'(cnt_model));
            if (prev_stall && !prev_flush) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", got[63:0], prev_out[63:0]);
                chk("hold_flags", 64'({got.taken, got.mis, got.ill}), 64'({prev_out.taken, prev_out.mis, prev_out.ill}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("taken", 64'(out_taken), 64'(e.taken));
                    chk("next_pc", out_next_pc, e.npc);
                    chk("mispredict", 64'(out_mispredict), 64'(e.mis));
                    chk("illegal", 64'(out_illegal), 64'(e.ill));
                    if (e.mis && cnt_model != '1) cnt_model = cnt_model + 1'b1;
                end
            end
            if (flush) exp_q.delete();
            if (in_valid && in_ready)
                exp_q.push_back(ref_model(in_a, in_b, in_funct3, in_pc, in_imm, in_pred_taken));
            prev_stall = out_valid && !out_ready;
            prev_out   = got;
            prev_flush = flush;
        end
    end

    task automatic set_in(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                          input logic [63:0] pc, input logic [63:0] imm, input logic pred);
        in_a = a; in_b = b; in_funct3 = f3; in_pc = pc; in_imm = imm; in_pred_taken = pred;
    endtask

    task automatic wait_accept(input string tag);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        chk({tag, "_accept"}, 64'(acc), 64'd1);
    endtask

    task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                           input logic [63:0] pc, input logic [63:0] imm,
                           input logic exp_taken, input logic [63:0] exp_npc, input logic exp_ill);
        logic seen;
        seen = 1'b0;
        set_in(a, b, f3, pc, imm, 1'b0);
        wait_accept(tag);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_valid"}, 64'(seen), 64'd1);
        chk({tag, "_taken"}, 64'(out_taken), 64'(exp_taken));
        chk({tag, "_next_pc"}, out_next_pc, exp_npc);
        chk({tag, "_illegal"}, 64'(out_illegal), 64'(exp_ill));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] fl [6];
        fl[0] = 3'b000; fl[1] = 3'b001; fl[2] = 3'b100;
        fl[3] = 3'b101; fl[4] = 3'b110; fl[5] = 3'b111;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_taken", 64'(out_taken), 64'd0);
        chk("rst_out_next_pc", out_next_pc, 64'd0);
        chk("rst_out_mispredict", 64'(out_mispredict), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst_cnt", 64'(mispredict_cnt), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;

        // BLT -1 < 1, predicted not-taken: 2-cycle latency, mispredict counted.
        set_in(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b100, 64'h1000, 64'h20, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_latency_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_latency_cycle2", 64'(out_valid), 64'd1);
        chk("t1_taken", 64'(out_taken), 64'd1);
        chk("t1_next_pc", out_next_pc, 64'h1020);
        chk("t1_mispredict", 64'(out_mispredict), 64'd1);
        @(negedge clk);
        chk("t1_cnt", 64'(mispredict_cnt), 64'd1);
        @(posedge clk);
        #1;

        run_one("t2_bltu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b110, 64'h2000, 64'h40, 1'b0, 64'h2004, 1'b0);
        run_one("t2_bgeu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b111, 64'h2000, 64'h40, 1'b1, 64'h2040, 1'b0);
        run_one("t3_beq",  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b000, 64'h3000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h2FF0, 1'b0);
        run_one("t3_bne",  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b001, 64'h3000, 64'h10, 1'b0, 64'h3004, 1'b0);
        run_one("t3_ill",  64'd5, 64'd5, 3'b010, 64'h3000, 64'h10, 1'b0, 64'h3004, 1'b1);
        run_one("t6_wrap", 64'd1, 64'd2, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b0, 64'd0, 1'b0);

        // Backpressure: two entries fill the pipe, the third waits.
        out_ready = 1'b0;
        set_in(64'd1, 64'd1, 3'b000, 64'h4000, 64'h100, 1'b0);
        wait_accept("t4_e1");
        set_in(64'd1, 64'd2, 3'b100, 64'h5000, 64'h200, 1'b1);
        wait_accept("t4_e2");
        set_in(64'd9, 64'd3, 3'b110, 64'h6000, 64'h300, 1'b1);
        in_valid = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("t4_in_ready_stalled", 64'(in_ready), 64'd0);
            chk("t4_out_valid_stalled", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        chk("t4_pending", 64'(exp_q.size()), 64'd2);
        out_ready = 1'b1;
        wait_accept("t4_e3");
        repeat (5) @(posedge clk);
        #1;
        chk("t4_drained", 64'(exp_q.size()), 64'd0);

        // Flush a full pipe; a same-cycle offer must be refused.
        out_ready = 1'b0;
        set_in(64'd7, 64'd7, 3'b000, 64'h7000, 64'h10, 1'b0);
        wait_accept("t5_e1");
        set_in(64'd7, 64'd8, 3'b001, 64'h7100, 64'h10, 1'b0);
        wait_accept("t5_e2");
        set_in(64'd3, 64'd4, 3'b100, 64'h7200, 64'h10, 1'b0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("t5_in_ready_flush", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_out_valid_after_flush", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("t5_no_flushed_output", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Sign-extended 8-bit operand sweep over all six conditions.
        for (int i = 0; i < 256; i += 15) begin
            for (int j = 0; j < 256; j += 15) begin
                for (int k = 0; k < 6; k++) begin
                    set_in(sx8(i), sx8(j), fl[k], {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
                    wait_accept("sweep");
                end
            end
        end

        // Random traffic with backpressure and occasional flushes.
        for (int t = 0; t < 2000; t++) begin
            logic [63:0] ra;
            ra = {$urandom, $urandom};
            set_in(ra, ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom}, 3'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("final_drained", 64'(exp_q.size()), 64'd0);
        chk("cnt_saturated", 64'(mispredict_cnt), 64'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
